// File: rtl/mac_learn_arbiter.sv
// mac_learn_arbiter: per-port source-address learn queue with round-robin write grant.
// Optional build macro MAC_ARB_DROP_CNT_EN adds a saturating dropped-request counter.
module mac_learn_arbiter #(
    parameter int pMAX_PORT_NUMBER = 4,
    parameter int pADRESS          = 2,
    parameter int pMAC_W           = 48
) (
    input  logic                               iclk,
    input  logic                               irst,
    input  logic [pMAX_PORT_NUMBER-1:0]        i_newSA,
    input  logic [pMAX_PORT_NUMBER*pMAC_W-1:0] i_SA,
    input  logic                               i_write_rdy,
    output logic                               o_write_en,
    output logic [pADRESS-1:0]                 o_port_num,
    output logic [pMAC_W-1:0]                  o_SA,
    output logic [pMAX_PORT_NUMBER-1:0]        o_show_SA
`ifdef MAC_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                        o_drop_cnt
`endif
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [pADRESS:0] NUM_P = (pADRESS+1)'(pMAX_PORT_NUMBER);
    localparam logic [pADRESS:0] LAST_P = (pADRESS+1)'(pMAX_PORT_NUMBER - 1);

    state_e                                   state_q, state_d;
    logic                                     wen_q, wen_d;
    logic [pADRESS-1:0]                       port_q, port_d;
    logic [pMAC_W-1:0]                        osa_q, osa_d;
    logic [pADRESS-1:0]                       ptr_q, ptr_d;
    logic [pMAX_PORT_NUMBER-1:0]              show_q;
    logic [pMAX_PORT_NUMBER-1:0][pMAC_W-1:0]  sa_q;

    logic                                     xfer;
    logic [pMAX_PORT_NUMBER-1:0]              xfer_oh;
    logic [pMAX_PORT_NUMBER-1:0]              drop_vec;
    logic [pMAX_PORT_NUMBER-1:0]              take_vec;
    logic                                     found;
    logic [pADRESS-1:0]                       sel;
    logic [pADRESS:0]                         idx_w;

    // Round-robin search for the first pending port at or above the pointer
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx_w = '0;
        for (int i = 0; i < pMAX_PORT_NUMBER; i++) begin
            idx_w = {1'b0, ptr_q} + (pADRESS+1)'(i);
            if (idx_w >= NUM_P) begin
                idx_w = idx_w - NUM_P;
            end
            if (!found && show_q[idx_w[pADRESS-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[pADRESS-1:0];
            end
        end
    end

    // Grant FSM next state and registered outputs
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        port_d  = port_q;
        osa_d   = osa_q;
        ptr_d   = ptr_q;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    wen_d   = 1'b1;
                    port_d  = sel;
                    osa_d   = sa_q[sel];
                end
            end
            GRANT: begin
                if (wen_q && i_write_rdy) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                    wen_d   = 1'b0;
                    if ({1'b0, port_q} == LAST_P) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = port_q + pADRESS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-port capture/drop decision; a port being transferred accepts a new pulse
    always_comb begin
        xfer_oh  = '0;
        drop_vec = '0;
        take_vec = '0;
        for (int k = 0; k < pMAX_PORT_NUMBER; k++) begin
            xfer_oh[k]  = xfer && (port_q == pADRESS'(k));
            drop_vec[k] = i_newSA[k] && show_q[k] && !xfer_oh[k];
            take_vec[k] = i_newSA[k] && !drop_vec[k];
        end
    end

    // FSM state and grant output registers
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            port_q  <= '0;
            osa_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            port_q  <= port_d;
            osa_q   <= osa_d;
            ptr_q   <= ptr_d;
        end
    end

    // Pending SA registers and pending flags
    always_ff @(posedge iclk) begin
        if (irst) begin
            show_q <= '0;
            sa_q   <= '0;
        end else begin
            for (int k = 0; k < pMAX_PORT_NUMBER; k++) begin
                if (take_vec[k]) begin
                    sa_q[k]   <= i_SA[k*pMAC_W +: pMAC_W];
                    show_q[k] <= 1'b1;
                end else if (xfer_oh[k]) begin
                    show_q[k] <= 1'b0;
                end
            end
        end
    end

`ifdef MAC_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [5:0]  drops_n;
    logic [16:0] drop_sum;

    // Count of pulses dropped this edge
    always_comb begin
        drops_n = '0;
        for (int k = 0; k < pMAX_PORT_NUMBER; k++) begin
            drops_n = drops_n + 6'(drop_vec[k]);
        end
        drop_sum = {1'b0, drop_cnt_q} + 17'(drops_n);
    end

    // Saturating dropped-request counter
    always_ff @(posedge iclk) begin
        if (irst) begin
            drop_cnt_q <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt_q <= 16'hFFFF;
        end else begin
            drop_cnt_q <= drop_sum[15:0];
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

    assign o_write_en = wen_q;
    assign o_port_num = port_q;
    assign o_SA       = osa_q;
    assign o_show_SA  = show_q;

endmodule

// File: tb/tb_mac_learn_arbiter.sv
// tb_mac_learn_arbiter: table vectors, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mac_learn_arbiter;

    localparam int N = 4;
    localparam int A = 2;
    localparam int W = 48;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     nsa;
    logic [N*W-1:0]   sa_bus;
    logic             rdy;
    logic             wen;
    logic [A-1:0]     port;
    logic [W-1:0]     osa;
    logic [N-1:0]     show;
`ifdef MAC_ARB_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    mac_learn_arbiter #(
        .pMAX_PORT_NUMBER(N),
        .pADRESS(A),
        .pMAC_W(W)
    ) dut (
        .iclk(clk),
        .irst(rst),
        .i_newSA(nsa),
        .i_SA(sa_bus),
        .i_write_rdy(rdy),
        .o_write_en(wen),
        .o_port_num(port),
        .o_SA(osa),
        .o_show_SA(show)
`ifdef MAC_ARB_DROP_CNT_EN
        ,
        .o_drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] nsa;
        logic         rdy;
        logic         wen;
        logic [A-1:0] port;
        logic [N-1:0] show;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [W-1:0] sa_const(int k);
        return 48'h0011_2233_4400 + 48'(k);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_const_sa();
        for (int k = 0; k < N; k++) sa_bus[k*W +: W] = sa_const(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nsa = '0;
        tick();
        rst = 1'b0;
    endtask

    // reference model: pending set, stored SAs, pointer, current grant
    bit [N-1:0]   m_show;
    logic [W-1:0] m_sa [N];
    bit           m_wen;
    int           m_port;
    logic [W-1:0] m_osa;
    int           m_ptr;
    int           m_drop;

    task automatic model_edge(logic r, logic [N-1:0] p, logic d, logic [N*W-1:0] bus);
        bit           x;
        int           gp;
        logic [W-1:0] gsa;
        if (r) begin
            m_show = '0;
            for (int k = 0; k < N; k++) m_sa[k] = '0;
            m_wen = 0; m_port = 0; m_osa = '0; m_ptr = 0; m_drop = 0;
            return;
        end
        x   = m_wen && d;
        gp  = -1;
        gsa = '0;
        if (!m_wen) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (gp < 0 && m_show[c]) gp = c;
            end
            if (gp >= 0) gsa = m_sa[gp];
        end
        for (int k = 0; k < N; k++) begin
            bit mine;
            mine = x && (m_port == k);
            if (p[k]) begin
                if (!m_show[k] || mine) begin
                    m_sa[k] = bus[k*W +: W];
                    m_show[k] = 1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end else if (mine) begin
                m_show[k] = 0;
            end
        end
        if (x) begin
            m_wen = 0;
            m_ptr = (m_port + 1) % N;
        end else if (gp >= 0) begin
            m_wen = 1;
            m_port = gp;
            m_osa = gsa;
        end
    endtask

    initial begin
        rst = 1'b1;
        nsa = '0;
        rdy = 1'b1;
        sa_bus = '0;
        set_const_sa();

        // reset, all four ports, then pointer wrap
        tbl[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'hF};
        tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'hF};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'hE};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 4'hE};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'hC};
        tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 4'hC};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h8};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
        tbl[10] = '{1'b0, 4'h9, 1'b1, 1'b0, 2'd0, 4'h9};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h9};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h8};
        tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 4'h8};
        tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst;
            nsa = tbl[i].nsa;
            rdy = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d wen", i), 64'(wen), 64'(tbl[i].wen));
            chk($sformatf("tbl%0d show", i), 64'(show), 64'(tbl[i].show));
            if (tbl[i].wen || tbl[i].rst) begin
                chk($sformatf("tbl%0d port", i), 64'(port), 64'(tbl[i].port));
                chk($sformatf("tbl%0d sa", i), 64'(osa),
                    tbl[i].rst ? 64'd0 : 64'(sa_const(int'(tbl[i].port))));
            end
        end
        nsa = '0;

        // single request latency
        do_reset();
        rdy = 1'b1;
        sa_bus[2*W +: W] = 48'h0011_2233_4455;
        nsa = 4'b0100;
        tick();
        nsa = '0;
        tick();
        chk("lat wen c2", 64'(wen), 64'd1);
        chk("lat port c2", 64'(port), 64'd2);
        chk("lat sa c2", 64'(osa), 64'h0011_2233_4455);
        tick();
        chk("lat wen c3", 64'(wen), 64'd0);
        chk("lat show c3", 64'(show), 64'd0);
        set_const_sa();

        // backpressure holds grant stable
        do_reset();
        rdy = 1'b0;
        nsa = 4'b0010;
        tick();
        nsa = '0;
        tick();
        chk("bp first grant", 64'(port), 64'd1);
        nsa = 4'b0001;
        tick();
        nsa = '0;
        for (int i = 0; i < 9; i++) begin
            chk("bp hold wen", 64'(wen), 64'd1);
            chk("bp hold port", 64'(port), 64'd1);
            chk("bp hold sa", 64'(osa), 64'(sa_const(1)));
            tick();
        end
        chk("bp show", 64'(show), 64'h3);
        rdy = 1'b1;
        tick();
        chk("bp xfer wen", 64'(wen), 64'd0);
        chk("bp xfer show", 64'(show), 64'h1);
        tick();
        chk("bp next wen", 64'(wen), 64'd1);
        chk("bp next port", 64'(port), 64'd0);
        tick();

        // second pulse on a pending port is dropped
        do_reset();
        rdy = 1'b0;
        sa_bus[2*W +: W] = 48'h1234;
        nsa = 4'b0110;
        tick();
        nsa = '0;
        tick();
        chk("drop grant1", 64'(port), 64'd1);
        sa_bus[2*W +: W] = 48'hAA;
        nsa = 4'b0100;
        tick();
        nsa = '0;
        chk("drop show", 64'(show), 64'h6);
`ifdef MAC_ARB_DROP_CNT_EN
        chk("drop cnt", 64'(drop_cnt), 64'd1);
`endif
        rdy = 1'b1;
        tick();
        chk("drop xfer wen", 64'(wen), 64'd0);
        tick();
        chk("drop grant2 port", 64'(port), 64'd2);
        chk("drop grant2 sa", 64'(osa), 64'h1234);
        tick();
        set_const_sa();

        // re-request on the transferring port is kept
        do_reset();
        rdy = 1'b1;
        sa_bus[0 +: W] = 48'h111;
        nsa = 4'b0001;
        tick();
        nsa = '0;
        tick();
        chk("same wen", 64'(wen), 64'd1);
        sa_bus[0 +: W] = 48'h222;
        nsa = 4'b0001;
        tick();
        nsa = '0;
        chk("same show", 64'(show), 64'h1);
        chk("same gap", 64'(wen), 64'd0);
        tick();
        chk("same regrant port", 64'(port), 64'd0);
        chk("same regrant sa", 64'(osa), 64'h222);
        tick();
        set_const_sa();

        // reset in the middle of a grant
        do_reset();
        rdy = 1'b0;
        nsa = 4'b0010;
        tick();
        nsa = '0;
        tick();
        chk("rstg wen before", 64'(wen), 64'd1);
        rst = 1'b1;
        nsa = 4'b1111;
        tick();
        rst = 1'b0;
        nsa = '0;
        chk("rstg wen", 64'(wen), 64'd0);
        chk("rstg port", 64'(port), 64'd0);
        chk("rstg sa", 64'(osa), 64'd0);
        chk("rstg show", 64'(show), 64'd0);
        tick();
        chk("rstg idle", 64'(wen), 64'd0);
        rdy = 1'b1;
        nsa = 4'b1000;
        tick();
        nsa = '0;
        tick();
        chk("rstg new wen", 64'(wen), 64'd1);
        chk("rstg new port", 64'(port), 64'd3);
        chk("rstg new sa", 64'(osa), 64'(sa_const(3)));

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++) begin
                nsa[k] = ($urandom_range(0, 3) == 0);
                sa_bus[k*W +: W] = {$urandom(), $urandom()} >> 16;
            end
            rdy = ($urandom_range(0, 2) != 0);
            model_edge(rst, nsa, rdy, sa_bus);
            tick();
            chk("rnd wen", 64'(wen), 64'(m_wen));
            chk("rnd show", 64'(show), 64'(m_show));
            if (m_wen) begin
                chk("rnd port", 64'(port), 64'(m_port));
                chk("rnd sa", 64'(osa), 64'(m_osa));
            end
`ifdef MAC_ARB_DROP_CNT_EN
            chk("rnd drop", 64'(drop_cnt), 64'(m_drop));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_learn_arbiter.md
MAC_LEARN_ARBITER -- requirements
Module: mac_learn_arbiter

Interface
REQ-001 The block SHALL have parameter pMAX_PORT_NUMBER, default 4, meaning the number of ports; the legal range is 2..32.
REQ-002 The block SHALL have parameter pADRESS, default 2, meaning the port-index width, equal to clog2(pMAX_PORT_NUMBER).
REQ-003 The block SHALL have parameter pMAC_W, default 48, meaning the source-address width.
REQ-004 The block SHALL have port iclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port irst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_newSA, input, pMAX_PORT_NUMBER bits: per-port one-cycle learn-request pulse.
REQ-007 The block SHALL have port i_SA, input, pMAX_PORT_NUMBER*pMAC_W bits: per-port SA; port k occupies bits [k*pMAC_W +: pMAC_W].
REQ-008 The block SHALL have port i_write_rdy, input, 1 bit: the MAC table accepts the write.
REQ-009 The block SHALL have port o_write_en, output, 1 bit: write request valid.
REQ-010 The block SHALL have port o_port_num, output, pADRESS bits: granted port index.
REQ-011 The block SHALL have port o_SA, output, pMAC_W bits: SA of the granted port.
REQ-012 The block SHALL have port o_show_SA, output, pMAX_PORT_NUMBER bits: per-port pending flag.

Function
REQ-013 An i_newSA[k] pulse on a non-pending port SHALL, at that edge, capture i_SA slice k into pending register k and set o_show_SA[k].
REQ-014 The FSM SHALL have two states, IDLE and GRANT; IDLE->GRANT occurs when any pending flag is set, and GRANT->IDLE occurs on an edge where o_write_en=1 and i_write_rdy=1.
REQ-015 Round-robin: in IDLE, the block SHALL select the first pending port searching from pointer p upward, wrapping pMAX_PORT_NUMBER-1 -> 0 (including non-power-of-2 counts), and register its index, SA and o_write_en=1.
REQ-016 Latency: i_newSA[k] in cycle 0 with nothing else pending SHALL give o_write_en=1, o_port_num=k and o_SA=SA_k in cycle 2.
REQ-017 In GRANT, o_write_en, o_port_num and o_SA SHALL remain stable until transfer, regardless of new requests.
REQ-018 On transfer of port k, the block SHALL clear o_show_SA[k], set p = (k+1) mod pMAX_PORT_NUMBER, and deassert o_write_en for at least one cycle.
REQ-019 An i_newSA[j] pulse while o_show_SA[j]=1 and j is not being transferred that edge SHALL be dropped; the stored SA is kept.
REQ-020 An i_newSA[k] pulse on the same edge as the transfer of port k SHALL be accepted: the new SA is captured and o_show_SA[k] stays 1.
REQ-021 Simultaneous pulses on several ports SHALL all be captured in the same cycle.
REQ-022 i_write_rdy while o_write_en=0 SHALL be ignored.

Reset
REQ-023 While irst=1 at an edge, the block SHALL set o_write_en=0, o_port_num=0, o_SA=0, o_show_SA=0, all pending registers=0, p=0, state=IDLE, and discard i_newSA.
REQ-024 Reset asserted in GRANT SHALL abandon the write with no transfer; the first request after reset release follows REQ-016.

Configuration
REQ-025 With macro MAC_ARB_DROP_CNT_EN defined, the block SHALL add port o_drop_cnt, output, 16 bits: a saturating count (holds at 65535) of pulses dropped per REQ-019, summed over ports per edge, reset to 0.
REQ-026 Without MAC_ARB_DROP_CNT_EN, the block SHALL have no o_drop_cnt port and no counter logic; all other behaviour is identical.

Verification (pMAX_PORT_NUMBER=4)
REQ-027 Scenario: i_newSA=4'b0100, SA2=48'h0011_2233_4455, i_write_rdy tied 1 -> cycle 2: o_write_en=1, o_port_num=2, o_SA=48'h0011_2233_4455; cycle 3: o_write_en=0, o_show_SA=0.
REQ-028 Scenario: i_newSA=4'b1111 in one cycle, i_write_rdy=1 -> grants in order 0,1,2,3, spaced 2 cycles apart.
REQ-029 Scenario: after port 3 is granted, pulse 4'b1001 -> next grant is port 0, then port 3 (pointer wrap).
REQ-030 Scenario: i_write_rdy=0 for 10 cycles during GRANT of port 1, with a port 0 pulse arriving -> o_port_num stays 1 and outputs stay stable; port 0 is granted after the transfer.
REQ-031 Scenario: port 2 pending but not granted, second pulse with SA 48'hAA -> original SA is written and o_drop_cnt=1 (with MAC_ARB_DROP_CNT_EN defined).
REQ-032 Scenario: irst=1 during GRANT -> all outputs 0 next cycle; a new pulse on port 3 after release gives a grant two cycles later.
